// File: rtl/hamming_secded_scrub_counter_if.sv
// Control and status bundle for the SEC-DED protected scrubbing counter.
// The master drives commands and fault injection; the slave returns count and error status.
interface hamming_secded_scrub_counter_if #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned PB    = WIDTH,
   parameter int unsigned CNT_W = 16
);
   logic                en;
   logic                up_dn;
   logic                load;
   logic [WIDTH-1:0]    load_val;
   logic                scrub_req;
   logic                clear_err;
   logic                inj_en;
   logic [WIDTH+PB-1:0] inj_mask;
   logic [WIDTH-1:0]    count;
   logic                scrub_busy;
   logic                err_corr;
   logic                err_uncorr;
   logic [CNT_W-1:0]    corr_cnt;

   modport master (
      output en, up_dn, load, load_val, scrub_req, clear_err, inj_en, inj_mask,
      input  count, scrub_busy, err_corr, err_uncorr, corr_cnt
   );

   modport slave (
      input  en, up_dn, load, load_val, scrub_req, clear_err, inj_en, inj_mask,
      output count, scrub_busy, err_corr, err_uncorr, corr_cnt
   );
endinterface

// File: rtl/hamming_secded_scrub_counter.sv
// Up/down/loadable counter stored as per-nibble SEC-DED Hamming(8,4) codewords,
// with on-the-fly correction and a background scrubber that rewrites corrected words.
module hamming_secded_scrub_counter #(
   parameter int unsigned WIDTH        = 32,
   parameter int unsigned SCRUB_PERIOD = 64,
   parameter int unsigned CNT_W        = 16
) (
   input logic                           clk,
   input logic                           reset,
   hamming_secded_scrub_counter_if.slave bus
);
   localparam int unsigned BLOCKS = WIDTH / 4;
   localparam int unsigned PB     = BLOCKS * 4;
   localparam int unsigned TW     = $clog2(SCRUB_PERIOD);

   typedef enum logic [1:0] {StIdle, StCheck, StWrite} state_e;

   // Check nibble layout: {c3, c2, c1, c0}
   function automatic logic [3:0] enc_chk(input logic [3:0] d);
      logic [2:0] c;
      c[0] = d[0] ^ d[1] ^ d[3];
      c[1] = d[0] ^ d[2] ^ d[3];
      c[2] = d[1] ^ d[2] ^ d[3];
      return {^{d, c}, c};
   endfunction

   function automatic logic [PB-1:0] enc_word(input logic [WIDTH-1:0] v);
      logic [PB-1:0] w;
      for (int i = 0; i < BLOCKS; i++) w[4*i +: 4] = enc_chk(v[4*i +: 4]);
      return w;
   endfunction

   logic [WIDTH-1:0]    data_q;
   logic [PB-1:0]       chk_q;
   logic [WIDTH+PB-1:0] word_d, lat_q, cor_word;
   logic [WIDTH-1:0]    cor_data, next_val;
   logic [BLOCKS-1:0]   sec_vec, ded_vec, sec_q;
   logic [TW-1:0]       timer_q, timer_d;
   logic [CNT_W-1:0]    corr_cnt_q;
   logic                err_corr_q, err_uncorr_q;
   logic                op_act, scrub_write;
   state_e              state_q, state_d;

   always_comb begin
      cor_data = data_q;
      sec_vec  = '0;
      ded_vec  = '0;
      for (int i = 0; i < BLOCKS; i++) begin
         logic [3:0] d, c, r;
         logic [2:0] syn;
         d   = data_q[4*i +: 4];
         c   = chk_q[4*i +: 4];
         r   = enc_chk(d);
         syn = r[2:0] ^ c[2:0];
         if (^{d, c}) begin
            sec_vec[i] = 1'b1;
            case (syn)
               3'b011:  d[0] = ~d[0];
               3'b101:  d[1] = ~d[1];
               3'b110:  d[2] = ~d[2];
               3'b111:  d[3] = ~d[3];
               default: ;
            endcase
         end else if (syn != 3'b000) begin
            ded_vec[i] = 1'b1;
         end
         cor_data[4*i +: 4] = d;
      end
   end

   assign cor_word = {enc_word(cor_data), cor_data};
   assign op_act   = bus.load | bus.en;
   assign next_val = bus.load  ? bus.load_val :
                     bus.up_dn ? cor_data + WIDTH'(1) : cor_data - WIDTH'(1);

   always_comb begin
      state_d     = state_q;
      timer_d     = timer_q;
      scrub_write = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (!op_act) timer_d = timer_q + 1'b1;
            if (bus.scrub_req || (!op_act && timer_q == TW'(SCRUB_PERIOD - 1))) begin
               state_d = StCheck;
               timer_d = '0;
            end
         end
         StCheck: state_d = op_act ? StIdle : StWrite;
         StWrite: begin
            state_d     = StIdle;
            scrub_write = !op_act;
         end
         default: state_d = StIdle;
      endcase
   end

   // Injection lands on whichever word is written this edge, including a plain hold.
   always_comb begin
      word_d = {chk_q, data_q};
      if (op_act)           word_d = {enc_word(next_val), next_val};
      else if (scrub_write) word_d = lat_q;
      if (bus.inj_en)       word_d = word_d ^ bus.inj_mask;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_q       <= '0;
         chk_q        <= '0;
         lat_q        <= '0;
         sec_q        <= '0;
         timer_q      <= '0;
         state_q      <= StIdle;
         err_corr_q   <= 1'b0;
         err_uncorr_q <= 1'b0;
         corr_cnt_q   <= '0;
      end else begin
         {chk_q, data_q} <= word_d;
         timer_q         <= timer_d;
         state_q         <= state_d;
         if (state_q == StCheck) begin
            lat_q <= cor_word;
            sec_q <= sec_vec;
         end
         err_corr_q <= scrub_write && (|sec_q);
         if (bus.clear_err) begin
            err_uncorr_q <= 1'b0;
            corr_cnt_q   <= '0;
         end else begin
            if (|ded_vec) err_uncorr_q <= 1'b1;
            if (scrub_write && (|sec_q) && corr_cnt_q != '1) corr_cnt_q <= corr_cnt_q + 1'b1;
         end
      end
   end

   assign bus.count      = cor_data;
   assign bus.scrub_busy = (state_q != StIdle);
   assign bus.err_corr   = err_corr_q;
   assign bus.err_uncorr = err_uncorr_q;
   assign bus.corr_cnt   = corr_cnt_q;
endmodule

// File: tb/tb_hamming_secded_scrub_counter.sv
// Self-checking bench for the SEC-DED scrubbing counter: directed scenarios plus a
// randomized run against a value-level model where any single-bit upset must be invisible.
module tb_hamming_secded_scrub_counter;
   localparam int unsigned WIDTH        = 32;
   localparam int unsigned PB           = 32;
   localparam int unsigned CNT_W        = 16;
   localparam int unsigned SCRUB_PERIOD = 64;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;

   hamming_secded_scrub_counter_if #(.WIDTH(WIDTH), .PB(PB), .CNT_W(CNT_W)) bus ();

   hamming_secded_scrub_counter #(
      .WIDTH(WIDTH), .SCRUB_PERIOD(SCRUB_PERIOD), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.en = 0; bus.up_dn = 0; bus.load = 0; bus.load_val = '0;
      bus.scrub_req = 0; bus.clear_err = 0; bus.inj_en = 0; bus.inj_mask = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1;
      step();
      reset = 0;
   endtask

   task automatic inject(input int bit_idx);
      bus.inj_mask = '0;
      bus.inj_mask[bit_idx] = 1'b1;
      bus.inj_en = 1;
      step();
      bus.inj_en = 0;
      bus.inj_mask = '0;
   endtask

   task automatic load_value(input logic [WIDTH-1:0] v);
      bus.load = 1; bus.load_val = v;
      step();
      bus.load = 0;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1;
      #2;
      checks++; if (bus.count !== '0) begin errors++; $display("FAIL reset_count got %h want 0", bus.count); end
      checks++; if (bus.scrub_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.scrub_busy); end
      checks++; if (bus.err_corr !== 1'b0) begin errors++; $display("FAIL reset_err_corr got %b want 0", bus.err_corr); end
      checks++; if (bus.err_uncorr !== 1'b0) begin errors++; $display("FAIL reset_err_uncorr got %b want 0", bus.err_uncorr); end
      checks++; if (bus.corr_cnt !== '0) begin errors++; $display("FAIL reset_corr_cnt got %0d want 0", bus.corr_cnt); end
      step();
      reset = 0;
   endtask

   task automatic test_count();
      do_reset();
      bus.en = 1; bus.up_dn = 1;
      repeat (5) step();
      checks++; if (bus.count !== 32'd5) begin errors++; $display("FAIL count_up got %h want 5", bus.count); end
      bus.up_dn = 0;
      repeat (6) step();
      checks++; if (bus.count !== 32'hFFFF_FFFF) begin errors++; $display("FAIL count_down_wrap got %h want ffffffff", bus.count); end
      bus.en = 0;
   endtask

   task automatic test_load();
      do_reset();
      load_value(32'hFFFF_FFFF);
      checks++; if (bus.count !== 32'hFFFF_FFFF) begin errors++; $display("FAIL load_ones got %h want ffffffff", bus.count); end
      bus.en = 1; bus.up_dn = 1;
      step();
      checks++; if (bus.count !== 32'h0) begin errors++; $display("FAIL up_wrap got %h want 0", bus.count); end
      bus.up_dn = 0;
      load_value(32'hA5A5_0F0F);
      bus.en = 0;
      checks++; if (bus.count !== 32'hA5A5_0F0F) begin errors++; $display("FAIL load_over_en got %h want a5a50f0f", bus.count); end
   endtask

   task automatic test_single_scrub();
      do_reset();
      load_value(32'h1234);
      inject(5);
      checks++; if (bus.count !== 32'h1234) begin errors++; $display("FAIL sec_count got %h want 1234", bus.count); end
      bus.scrub_req = 1;
      step();
      bus.scrub_req = 0;
      checks++; if (bus.scrub_busy !== 1'b1) begin errors++; $display("FAIL sec_busy got %b want 1", bus.scrub_busy); end
      step();
      step();
      checks++; if (bus.err_corr !== 1'b1) begin errors++; $display("FAIL sec_err_corr got %b want 1", bus.err_corr); end
      checks++; if (bus.corr_cnt !== 16'd1) begin errors++; $display("FAIL sec_corr_cnt got %0d want 1", bus.corr_cnt); end
      step();
      checks++; if (bus.err_corr !== 1'b0) begin errors++; $display("FAIL sec_pulse_width got %b want 0", bus.err_corr); end
      // A second upset in the same nibble is only harmless if the first one was scrubbed out.
      inject(6);
      step();
      checks++; if (bus.count !== 32'h1234) begin errors++; $display("FAIL sec_clean_count got %h want 1234", bus.count); end
      checks++; if (bus.err_uncorr !== 1'b0) begin errors++; $display("FAIL sec_clean_uncorr got %b want 0", bus.err_uncorr); end
   endtask

   task automatic test_c3();
      do_reset();
      load_value(32'hC7);
      inject(WIDTH + 3);
      checks++; if (bus.count !== 32'hC7) begin errors++; $display("FAIL c3_count got %h want c7", bus.count); end
      bus.scrub_req = 1;
      step();
      bus.scrub_req = 0;
      step();
      step();
      checks++; if (bus.corr_cnt !== 16'd1) begin errors++; $display("FAIL c3_corr_cnt got %0d want 1", bus.corr_cnt); end
      inject(0);
      step();
      checks++; if (bus.err_uncorr !== 1'b0) begin errors++; $display("FAIL c3_uncorr got %b want 0", bus.err_uncorr); end
      checks++; if (bus.count !== 32'hC7) begin errors++; $display("FAIL c3_after_count got %h want c7", bus.count); end
   endtask

   task automatic test_double();
      do_reset();
      load_value(32'h5);
      bus.inj_mask = 64'h3; bus.inj_en = 1;
      step();
      bus.inj_en = 0; bus.inj_mask = '0;
      checks++; if (bus.count !== 32'h6) begin errors++; $display("FAIL ded_raw got %h want 6", bus.count); end
      checks++; if (bus.err_uncorr !== 1'b0) begin errors++; $display("FAIL ded_early got %b want 0", bus.err_uncorr); end
      step();
      checks++; if (bus.err_uncorr !== 1'b1) begin errors++; $display("FAIL ded_flag got %b want 1", bus.err_uncorr); end
      repeat (3) step();
      checks++; if (bus.err_uncorr !== 1'b1) begin errors++; $display("FAIL ded_sticky got %b want 1", bus.err_uncorr); end
      bus.clear_err = 1;
      load_value(32'h9);
      bus.clear_err = 0;
      checks++; if (bus.err_uncorr !== 1'b0) begin errors++; $display("FAIL ded_clear got %b want 0", bus.err_uncorr); end
      checks++; if (bus.count !== 32'h9) begin errors++; $display("FAIL ded_reload got %h want 9", bus.count); end
      step();
      checks++; if (bus.err_uncorr !== 1'b0) begin errors++; $display("FAIL ded_stay_clear got %b want 0", bus.err_uncorr); end
   endtask

   task automatic test_abort();
      do_reset();
      load_value(32'h77);
      inject(9);
      bus.scrub_req = 1;
      step();
      bus.scrub_req = 0;
      step();
      bus.en = 1; bus.up_dn = 1;
      step();
      bus.en = 0;
      checks++; if (bus.err_corr !== 1'b0) begin errors++; $display("FAIL abort_err_corr got %b want 0", bus.err_corr); end
      checks++; if (bus.count !== 32'h78) begin errors++; $display("FAIL abort_count got %h want 78", bus.count); end
      checks++; if (bus.corr_cnt !== 16'd0) begin errors++; $display("FAIL abort_corr_cnt got %0d want 0", bus.corr_cnt); end
      checks++; if (bus.scrub_busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", bus.scrub_busy); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      load_value(32'h3C);
      inject(2);
      bus.scrub_req = 1;
      step();
      bus.scrub_req = 0;
      checks++; if (bus.scrub_busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before got %b want 1", bus.scrub_busy); end
      reset = 1;
      #2;
      checks++; if (bus.count !== '0) begin errors++; $display("FAIL mid_count got %h want 0", bus.count); end
      checks++; if (bus.scrub_busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %b want 0", bus.scrub_busy); end
      checks++; if ({bus.err_corr, bus.err_uncorr} !== 2'b00) begin errors++; $display("FAIL mid_flags got %b want 00", {bus.err_corr, bus.err_uncorr}); end
      checks++; if (bus.corr_cnt !== '0) begin errors++; $display("FAIL mid_corr_cnt got %0d want 0", bus.corr_cnt); end
      step();
      reset = 0;
   endtask

   task automatic test_auto_scrub();
      do_reset();
      inject(WIDTH + 8);
      repeat (SCRUB_PERIOD - 2) step();
      checks++; if (bus.scrub_busy !== 1'b0) begin errors++; $display("FAIL auto_early got %b want 0", bus.scrub_busy); end
      step();
      checks++; if (bus.scrub_busy !== 1'b1) begin errors++; $display("FAIL auto_busy got %b want 1", bus.scrub_busy); end
      step();
      step();
      checks++; if (bus.err_corr !== 1'b1) begin errors++; $display("FAIL auto_err_corr got %b want 1", bus.err_corr); end
      checks++; if (bus.count !== '0) begin errors++; $display("FAIL auto_count got %h want 0", bus.count); end
   endtask

   // Model is just the logical value: a lone upset anywhere must never change count.
   task automatic test_random();
      logic [WIDTH-1:0] model;
      do_reset();
      model = '0;
      for (int n = 0; n < 600; n++) begin
         bus.load      = ($urandom_range(99, 0) < 6);
         bus.en        = $urandom_range(1, 0);
         bus.up_dn     = $urandom_range(1, 0);
         bus.load_val  = $urandom;
         bus.scrub_req = ($urandom_range(19, 0) == 0);
         bus.inj_mask  = '0;
         bus.inj_mask[$urandom_range(WIDTH + PB - 1, 0)] = 1'b1;
         bus.inj_en    = (bus.load || bus.en) && ($urandom_range(3, 0) == 0);
         if (bus.load)    model = bus.load_val;
         else if (bus.en) model = bus.up_dn ? model + 1 : model - 1;
         step();
         checks++; if (bus.count !== model) begin errors++; $display("FAIL rand_count[%0d] got %h want %h", n, bus.count, model); end
      end
      idle_inputs();
      step();
      checks++; if (bus.err_uncorr !== 1'b0) begin errors++; $display("FAIL rand_uncorr got %b want 0", bus.err_uncorr); end
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_count();
      test_load();
      test_single_scrub();
      test_c3();
      test_double();
      test_abort();
      test_reset_mid();
      test_auto_scrub();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
